uart_tx_flow: RTL and testbench
===============================

// Module: uart_tx_flow
// PURPOSE
//   8N1 UART transmitter, FPGA -> PC direction, with hardware flow control.
//   Serialises a byte on the TX line and holds each frame until the host
//   asserts RTS. Complements the host-driven DTR/RTS inputs on the
//   IceZum FTDI interface.
//   Sits between user logic (byte + start strobe) and the FTDI TX pin.
// PARAMETERS
//   BAUD_DIV   104   clock cycles per bit (12 MHz / 115200); legal range >= 2
//   FLOW_CTRL  1     1: frames wait for rts; 0: rts is ignored (treated as 1)
// PORTS
//   clk     in   1  system clock; all logic on the rising edge
//   rstn    in   1  asynchronous, active-low reset
//   data    in   8  byte to send; sampled only in the cycle start is accepted
//   start   in   1  send request; accepted only when ready=1
//   rts     in   1  host flow control, asynchronous; 1 = host may receive
//   tx      out  1  serial line; idle high; registered
//   ready   out  1  1 = start will be accepted this cycle; registered
//   waiting out  1  1 = byte latched, frame held because rts_s=0
// BEHAVIOUR
//   Reset (rstn=0, immediate):
//   - tx=1, ready=1, waiting=0, FSM=IDLE.
//   - Counters, shift register and sync flops clear.
//   - A frame in flight is abandoned; tx goes high without delay.
//   rts synchroniser:
//   - Two-flop synchroniser produces rts_s; rts_s lags rts by 2 clocks.
//   - When FLOW_CTRL=0, rts_s is forced to 1.
//   FSM states: IDLE, WAIT_RTS, START, DATA, STOP.
//   - IDLE: on start=1 in cycle k, latch data, ready=0 at k+1.
//     - If rts_s=1 in cycle k, go to START.
//     - Otherwise go to WAIT_RTS.
//   - WAIT_RTS: waiting=1, tx=1.
//     - Stay until rts_s=1 in some cycle m, then go to START.
//     - tx goes low at m+1.
//   - START: tx=0 for exactly BAUD_DIV cycles.
//     - The baud counter restarts from 0 on entry.
//   - DATA: bits 0..7, LSB first, each BAUD_DIV cycles.
//   - STOP: tx=1 for BAUD_DIV cycles.
//     - ready=1 in the last stop-bit cycle, then return to IDLE.
//   Timing: frame start at cycle s (first tx=0 cycle) gives these windows:
//   - start bit [s, s+D-1]
//   - data bit i [s+(i+1)D, s+(i+2)D-1]
//   - stop bit [s+9D, s+10D-1], where D = BAUD_DIV
//   - ready=1 from s+10D-1 onward.
//   Boundary conditions:
//   - start while ready=0 is ignored; no queueing; data changes are ignored.
//   - start in the cycle ready reasserts is accepted (back-to-back).
//     - If rts_s=1, the next start bit begins at s+10D with zero idle gap.
//   - rts_s falling mid-frame does not abort or stretch the frame.
//     - Flow control is checked only before the start bit.
//   - rts toggling while in WAIT_RTS: only the first cycle with rts_s=1 matters.
//   - The baud counter width is clog2(BAUD_DIV). It wraps at BAUD_DIV-1 with no skew.
// TESTING (benches use BAUD_DIV=4, FLOW_CTRL=1 unless noted)
//   1 Reset: rstn=0 -> tx=1, ready=1, waiting=0.
//     Hold 5 cycles with start=1: no frame is sent.
//   2 rts=1, send 0x55 -> tx pattern 0,1,0,1,0,1,0,1,0,1 (start,LSB..MSB,stop).
//     Each level lasts exactly 4 cycles; ready=1 at the 40th frame cycle.
//   3 rts=0, send 0xA3 -> waiting=1, tx=1 for 20 cycles.
//     Raise rts: start bit appears 3 clocks later (2 sync + 1).
//     The bits sent are 1,1,0,0,0,1,0,1.
//   4 Back-to-back 0x00 then 0xFF, with start held high.
//     -> 80 contiguous cycles; stop bit directly followed by start bit.
//     -> A start pulse mid-frame is ignored.
//   5 Drop rts during data bit 3 -> frame completes unchanged.
//     The next start is accepted but held in WAIT_RTS.
//   6 Assert rstn=0 during data bit 5 -> tx=1 immediately.
//     After release, ready=1 and a new 0x3C frame is sent correctly.
//     Also rerun test 3 with FLOW_CTRL=0: the frame starts despite rts=0.

Source files
------------

// File: rtl/uart_tx_flow.sv
// 8N1 UART transmitter with RTS flow control: each accepted byte is held
// until the synchronised host RTS allows the frame to start.
module uart_tx_flow #(
  parameter int unsigned BAUD_DIV  = 104,
  parameter int unsigned FLOW_CTRL = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       start,
  input  logic       rts,
  output logic       tx,
  output logic       ready,
  output logic       waiting
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, WAIT_RTS, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    sh, sh_n;
  logic          tx_n, ready_n, waiting_n;
  logic          rts_m, rts_q, rts_s;
  logic          accept, bit_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rts_m <= 1'b0;
      rts_q <= 1'b0;
    end else begin
      rts_m <= rts;
      rts_q <= rts_m;
    end
  end

  assign rts_s   = (FLOW_CTRL != 0) ? rts_q : 1'b1;
  assign accept  = start & ready;
  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitn_n  = bitn;
    sh_n    = sh;
    case (state)
      IDLE: begin
        if (accept) begin
          sh_n    = data;
          cnt_n   = '0;
          state_n = rts_s ? START : WAIT_RTS;
        end
      end
      WAIT_RTS: begin
        if (rts_s) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          bitn_n  = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n  = '0;
          sh_n   = {1'b0, sh[7:1]};
          bitn_n = bitn + 1'b1;
          if (bitn == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        // A start taken in the last stop cycle chains straight into the next frame.
        if (bit_end) begin
          cnt_n = '0;
          if (accept) begin
            sh_n    = data;
            state_n = rts_s ? START : WAIT_RTS;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with it.
    tx_n = 1'b1;
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = sh_n[0];
    ready_n   = (state_n == IDLE) || ((state_n == STOP) && (cnt_n == CNT_LAST));
    waiting_n = (state_n == WAIT_RTS);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bitn    <= '0;
      sh      <= '0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      waiting <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bitn    <= bitn_n;
      sh      <= sh_n;
      tx      <= tx_n;
      ready   <= ready_n;
      waiting <= waiting_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Bench for uart_tx_flow: frame table, directed corner sequences and random
// traffic checked against a queue-of-line-levels reference model.
module tb_uart_tx_flow;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] data = '0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       rts = 1'b0;
  logic       tx, ready, waiting;
  logic       tx2, ready2, waiting2;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: expected line level per future cycle of the current frame.
  bit         mq[$];
  bit         m_hold = 1'b0;
  logic [7:0] m_pend = '0;
  bit         h1 = 1'b0, h2 = 1'b0;
  bit         m_tx = 1'b1, m_ready = 1'b1, m_wait = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       rts;
    int         hold;
    logic [9:0] frame;
    int         lat;
  } vec_t;
  vec_t vt[5];

  uart_tx_flow #(.BAUD_DIV(D), .FLOW_CTRL(1)) dut (
    .clk(clk), .rstn(rstn), .data(data), .start(start), .rts(rts),
    .tx(tx), .ready(ready), .waiting(waiting)
  );

  uart_tx_flow #(.BAUD_DIV(D), .FLOW_CTRL(0)) dut_nf (
    .clk(clk), .rstn(rstn), .data(data), .start(start2), .rts(rts),
    .tx(tx2), .ready(ready2), .waiting(waiting2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [7:0] b);
    for (int slot = 0; slot < 10; slot++) begin
      bit lvl;
      if (slot == 0)      lvl = 1'b0;
      else if (slot == 9) lvl = 1'b1;
      else                lvl = b[slot-1];
      for (int r = 0; r < D; r++) mq.push_back(lvl);
    end
  endfunction

  // Advances the model by the clock edge that preceded the current negedge.
  task automatic model_step();
    bit rs, acc;
    if (!rstn) begin
      mq.delete();
      m_hold = 1'b0; h1 = 1'b0; h2 = 1'b0;
      m_tx = 1'b1; m_ready = 1'b1; m_wait = 1'b0;
    end else begin
      rs  = h2;
      acc = start && m_ready;
      if (mq.size() > 0) void'(mq.pop_front());
      if (m_hold && rs) begin
        m_hold = 1'b0;
        push_frame(m_pend);
      end
      if (acc) begin
        if (rs) push_frame(data);
        else begin
          m_hold = 1'b1;
          m_pend = data;
        end
      end
      h2 = h1;
      h1 = rts;
      m_tx    = (mq.size() > 0) ? mq[0] : 1'b1;
      m_wait  = m_hold;
      m_ready = !m_hold && (mq.size() <= 1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    check("model", 32'({tx, ready, waiting}), 32'({m_tx, m_ready, m_wait}));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    rts = v.rts;
    if (!v.rts) repeat (3) tick();
    wait_ready();
    start = 1'b1;
    data  = v.data;
    tick();
    start = 1'b0;
    data  = 8'($urandom);
    lat = 1;
    if (v.hold > 0) begin
      for (int i = 0; i < v.hold; i++) begin
        check("hold", 32'({tx, ready, waiting}), 32'b101);
        tick();
      end
      rts = 1'b1;
      lat = 0;
    end
    while (tx !== 1'b0 && lat < 30) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(v.lat));
    for (int j = 0; j < 40; j++) begin
      check("frame_bit", 32'(tx), 32'(v.frame[j/D]));
      check("frame_ready", 32'(ready), 32'(j == 39));
      if (j < 39) tick();
    end
  endtask

  initial begin
    logic [9:0] f;
    vt[0] = '{8'h55, 1'b1, 0,  10'b1010101010, 1};
    vt[1] = '{8'hA3, 1'b0, 20, 10'b1101000110, 3};
    vt[2] = '{8'h00, 1'b1, 0,  10'b1000000000, 1};
    vt[3] = '{8'hFF, 1'b1, 0,  10'b1111111110, 1};
    vt[4] = '{8'h3C, 1'b1, 0,  10'b1001111000, 1};

    // Reset held with start asserted: nothing leaves the line.
    start = 1'b1; data = 8'hFF; rts = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_state", 32'({tx, ready, waiting}), 32'b110);
    end
    start = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    check("idle_after_reset", 32'({tx, ready, waiting}), 32'b110);

    foreach (vt[k]) run_vec(vt[k]);

    // Back-to-back 0x00 then 0xFF with start held high, plus an ignored mid-frame pulse.
    rts = 1'b1;
    wait_ready();
    start = 1'b1; data = 8'h00;
    for (int i = 1; i <= 88; i++) begin
      tick();
      f = (i <= 40) ? 10'b1000000000 : 10'b1111111110;
      if (i <= 80) check("b2b_tx", 32'(tx), 32'(f[((i-1)%40)/D]));
      else         check("b2b_idle", 32'({tx, ready, waiting}), 32'b110);
      if (i == 40) check("b2b_ready", 32'(ready), 32'd1);
      if (i == 1) data = 8'hFF;
      if (i == 41) begin start = 1'b0; data = 8'hA5; end
      if (i == 60) start = 1'b1;
      if (i == 61) start = 1'b0;
    end

    // RTS dropped during data bit 3: frame unchanged, next byte parked in WAIT_RTS.
    wait_ready();
    start = 1'b1; data = 8'h3C;
    f = 10'b1001111000;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (i <= 40) check("rtsdrop_tx", 32'(tx), 32'(f[(i-1)/D]));
      if (i >= 41) check("rtsdrop_held", 32'({tx, ready, waiting}), 32'b101);
      if (i == 18) rts = 1'b0;
      if (i == 40) begin
        check("rtsdrop_ready", 32'(ready), 32'd1);
        start = 1'b1; data = 8'h81;
      end
      if (i == 41) start = 1'b0;
    end
    rts = 1'b1;
    wait_ready();
    repeat (2) tick();

    // Asynchronous reset during data bit 5 of 0xC3, then a clean 0x3C frame.
    wait_ready();
    start = 1'b1; data = 8'hC3;
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (i == 1) start = 1'b0;
    end
    check("rst_mid_pre", 32'(tx), 32'd0);
    #2 rstn = 1'b0;
    #1 check("rst_async", 32'({tx, ready, waiting}), 32'b110);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    check("rst_release", 32'(ready), 32'd1);
    run_vec('{8'h3C, 1'b1, 0, 10'b1001111000, 1});

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      tick();
      start = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      if ($urandom_range(0, 24) == 0) rts = ~rts;
    end
    start = 1'b0;
    rts = 1'b1;
    wait_ready();
    repeat (45) tick();

    // FLOW_CTRL=0 instance starts immediately despite rts=0.
    rts = 1'b0;
    repeat (3) tick();
    start2 = 1'b1; data = 8'hA3;
    tick();
    start2 = 1'b0;
    check("nf_start", 32'({tx2, waiting2}), 32'b00);
    f = 10'b1101000110;
    for (int j = 0; j < 40; j++) begin
      check("nf_bit", 32'(tx2), 32'(f[j/D]));
      check("nf_ready", 32'(ready2), 32'(j == 39));
      if (j < 39) tick();
    end
    tick();
    check("nf_idle", 32'({tx2, ready2, waiting2}), 32'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
